reg_bank_wb: RTL

Writeback-side register bank: the receiving end of the instruction-register-to-register-bank (IR-RB) path. It accepts the already-selected 4-bit destination index and 32-bit result, stores them in a 16 x 32 register file, and serves two same-cycle-forwarded read ports. A per-register busy scoreboard gives decode a reserve/writeback handshake for RAW and WAW hazard detection.

---
 rtl/reg_bank_wb_if.sv | 41 ++++
 rtl/reg_bank_wb.sv | 117 +++++++++++
 2 files changed

// File: rtl/reg_bank_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_wb_if
// Description : Bus bundle between decode/writeback logic (master) and the
//               writeback-side register bank (slave): two read ports, the
//               reservation handshake, the writeback channel and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_wb_if #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16
);
   logic [3:0]        rs1_addr;
   logic [DATA_W-1:0] rs1_data;
   logic              rs1_busy;
   logic [3:0]        rs2_addr;
   logic [DATA_W-1:0] rs2_data;
   logic              rs2_busy;
   logic              rsv_valid;
   logic [3:0]        rsv_addr;
   logic              rsv_ready;
   logic              wr_valid;
   logic [3:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic [NREG-1:0]   busy_vec;
   logic              wr_err;

   modport master (
      output rs1_addr, rs2_addr, rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data,
      input  rs1_data, rs1_busy, rs2_data, rs2_busy, rsv_ready, wr_ready,
             busy_vec, wr_err
   );

   modport slave (
      input  rs1_addr, rs2_addr, rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data,
      output rs1_data, rs1_busy, rs2_data, rs2_busy, rsv_ready, wr_ready,
             busy_vec, wr_err
   );
endinterface
`default_nettype wire

// File: rtl/reg_bank_wb.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_wb
// Description : Writeback-side 16 x 32 register bank with two forwarded
//               combinational read ports and a per-register busy scoreboard
//               (reserve/writeback handshake for RAW/WAW hazard detection).
//               Optional feature macro: REG0_ZERO_EN (hard-wired zero r0).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_wb #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   reg_bank_wb_if.slave     bus
);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_busy;
   logic              r_wr_err;
   logic              r_wr_ready;

   logic              w_wr_fire;
   logic              w_wr_eff;
   logic              w_rsv_ready;
   logic              w_rsv_eff;
   logic [NREG-1:0]   w_busy_nxt;
   logic              w_rs1_hit;
   logic              w_rs2_hit;
   logic [DATA_W-1:0] w_rs1_data;
   logic [DATA_W-1:0] w_rs2_data;

   assign w_wr_fire = bus.wr_valid & r_wr_ready;

   // A retiring write to the same register frees it for a new reservation.
   assign w_rsv_ready = ~r_busy[bus.rsv_addr] |
                        (w_wr_fire & (bus.wr_addr == bus.rsv_addr));

`ifdef REG0_ZERO_EN
   // r0 is hard-wired: its writes and reservations never touch state.
   assign w_wr_eff  = w_wr_fire & (bus.wr_addr != 4'd0);
   assign w_rsv_eff = bus.rsv_valid & w_rsv_ready & (bus.rsv_addr != 4'd0);
`else
   assign w_wr_eff  = w_wr_fire;
   assign w_rsv_eff = bus.rsv_valid & w_rsv_ready;
`endif

   assign w_rs1_hit = w_wr_eff & (bus.wr_addr == bus.rs1_addr);
   assign w_rs2_hit = w_wr_eff & (bus.wr_addr == bus.rs2_addr);

   // Scoreboard next state: writeback clears first, so a same-cycle
   // reservation of the same register leaves it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_eff) begin
         w_busy_nxt[bus.wr_addr] = 1'b0;
      end
      if (w_rsv_eff) begin
         w_busy_nxt[bus.rsv_addr] = 1'b1;
      end
`ifdef REG0_ZERO_EN
      w_busy_nxt[0] = 1'b0;
`endif
   end

   // Read ports: same-cycle writeback data bypasses the register file.
   always_comb begin
      w_rs1_data = w_rs1_hit ? bus.wr_data : r_regs[bus.rs1_addr];
      w_rs2_data = w_rs2_hit ? bus.wr_data : r_regs[bus.rs2_addr];
`ifdef REG0_ZERO_EN
      if (bus.rs1_addr == 4'd0) begin
         w_rs1_data = '0;
      end
      if (bus.rs2_addr == 4'd0) begin
         w_rs2_data = '0;
      end
`endif
   end

   // Register file storage; reset clears every entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_eff) begin
         r_regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Control state: scoreboard, sticky error flag and write-accept flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_wr_err   <= 1'b0;
         r_wr_ready <= 1'b0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_wr_ready <= 1'b1;
         if (w_wr_eff && !r_busy[bus.wr_addr]) begin
            r_wr_err <= 1'b1;
         end
      end
   end

   assign bus.rs1_data  = w_rs1_data;
   assign bus.rs2_data  = w_rs2_data;
   assign bus.rs1_busy  = r_busy[bus.rs1_addr] & ~w_rs1_hit;
   assign bus.rs2_busy  = r_busy[bus.rs2_addr] & ~w_rs2_hit;
   assign bus.rsv_ready = w_rsv_ready;
   assign bus.wr_ready  = r_wr_ready;
   assign bus.busy_vec  = r_busy;
   assign bus.wr_err    = r_wr_err;

endmodule
`default_nettype wire
